// File: rtl/rcv_fifo_pkg.sv
// rcv_fifo_pkg
//   Shared defaults and width helpers for the receive block FIFO.
//   No ports; imported by rcv_block_fifo_if, rcv_word_packer and rcv_block_fifo.
package rcv_fifo_pkg;

   localparam int WORD_W_DEF    = 32;
   localparam int WPB_DEF       = 4;
   localparam int DEPTH_DEF     = 3;
   localparam int AF_THRESH_DEF = 2;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of an index 0..n-1; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rcv_block_fifo_if.sv
// rcv_block_fifo_if
//   Bus bundle between the AHB-slave write side / cipher read side and the FIFO.
//   master : drives HWDATA, rcv_enq_word, rcv_deq, fix_error, flush
//   slave  : drives rcv_fifo_out, full, empty, almost_full, blk_count,
//            framing_error, overflow, underflow
interface rcv_block_fifo_if
   import rcv_fifo_pkg::*;
#(
   parameter int WORD_W        = WORD_W_DEF,
   parameter int WORDS_PER_BLK = WPB_DEF,
   parameter int DEPTH         = DEPTH_DEF
) ();

   localparam int BLK_W = WORD_W * WORDS_PER_BLK;
   localparam int CNT_W = cnt_w(DEPTH);

   logic [WORD_W-1:0] HWDATA;
   logic              rcv_enq_word;
   logic              rcv_deq;
   logic              fix_error;
   logic              flush;
   logic [BLK_W-1:0]  rcv_fifo_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [CNT_W-1:0]  blk_count;
   logic              framing_error;
   logic              overflow;
   logic              underflow;

   modport master (
      output HWDATA, rcv_enq_word, rcv_deq, fix_error, flush,
      input  rcv_fifo_out, full, empty, almost_full, blk_count,
             framing_error, overflow, underflow
   );

   modport slave (
      input  HWDATA, rcv_enq_word, rcv_deq, fix_error, flush,
      output rcv_fifo_out, full, empty, almost_full, blk_count,
             framing_error, overflow, underflow
   );

endinterface

// File: rtl/rcv_word_packer.sv
// rcv_word_packer
//   Collects WORDS_PER_BLK words into one block, first word in the MSBs.
//   clk, n_rst     : clock, async active-low reset
//   word           : incoming bus word
//   accept         : word is taken this cycle (already gated by FIFO space)
//   clear          : drop the partial block (flush / fix_error)
//   blk_data       : assembled block including the current word (combinational)
//   blk_valid      : pulse, accepted word completes a block this cycle
//   framing_error  : a partial block is held
module rcv_word_packer
   import rcv_fifo_pkg::*;
#(
   parameter int WORD_W        = WORD_W_DEF,
   parameter int WORDS_PER_BLK = WPB_DEF
) (
   input  logic                              clk,
   input  logic                              n_rst,
   input  logic [WORD_W-1:0]                 word,
   input  logic                              accept,
   input  logic                              clear,
   output logic [WORD_W*WORDS_PER_BLK-1:0]   blk_data,
   output logic                              blk_valid,
   output logic                              framing_error
);

   localparam int BLK_W = WORD_W * WORDS_PER_BLK;
   localparam int WC_W  = idx_w(WORDS_PER_BLK);

   logic [WC_W-1:0]  wc;
   logic [BLK_W-1:0] asm_q;
   logic             last;

   assign last = (wc == WC_W'(WORDS_PER_BLK - 1));

   // Splice the live word into its slot so the completing word can be
   // written to memory on the same edge it arrives.
   for (genvar k = 0; k < WORDS_PER_BLK; k++) begin : g_slot
      assign blk_data[BLK_W-1-k*WORD_W -: WORD_W] =
         (wc == WC_W'(k)) ? word : asm_q[BLK_W-1-k*WORD_W -: WORD_W];
   end

   assign blk_valid     = accept & last;
   assign framing_error = (wc != '0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wc    <= '0;
         asm_q <= '0;
      end else if (clear) begin
         wc    <= '0;
         asm_q <= '0;
      end else if (accept) begin
         if (last) begin
            wc    <= '0;
            asm_q <= '0;
         end else begin
            wc    <= wc + WC_W'(1);
            asm_q <= blk_data;
         end
      end
   end

endmodule

// File: rtl/rcv_block_fifo.sv
// rcv_block_fifo
//   Receive FIFO: packs bus words into blocks and stores up to DEPTH blocks
//   for the cipher core, head block shown first-word-fall-through.
//   clk    : clock, rising edge
//   n_rst  : async active-low reset
//   bus    : slave side of rcv_block_fifo_if
//            in : HWDATA, rcv_enq_word, rcv_deq, fix_error, flush
//            out: rcv_fifo_out, full, empty, almost_full, blk_count,
//                 framing_error, overflow (sticky), underflow (sticky)
module rcv_block_fifo
   import rcv_fifo_pkg::*;
#(
   parameter int WORD_W        = WORD_W_DEF,
   parameter int WORDS_PER_BLK = WPB_DEF,
   parameter int DEPTH         = DEPTH_DEF,
   parameter int AF_THRESH     = AF_THRESH_DEF
) (
   input  logic           clk,
   input  logic           n_rst,
   rcv_block_fifo_if.slave bus
);

   localparam int BLK_W = WORD_W * WORDS_PER_BLK;
   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = idx_w(DEPTH);

   logic [BLK_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             ovf_q, unf_q;

   logic             full_w, empty_w, clear, accept, reject, push, pop;
   logic [BLK_W-1:0] blk_data;
   logic             blk_valid, frm_err;

   // Explicit wrap since DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_w  = (count == CNT_W'(DEPTH));
   assign empty_w = (count == '0);
   assign clear   = bus.flush | bus.fix_error;

   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign accept = bus.rcv_enq_word & (~full_w | bus.rcv_deq) & ~clear;
   assign reject = bus.rcv_enq_word & full_w & ~bus.rcv_deq & ~clear;
   assign push   = blk_valid;
   assign pop    = bus.rcv_deq & ~empty_w & ~bus.flush;

   rcv_word_packer #(
      .WORD_W        (WORD_W),
      .WORDS_PER_BLK (WORDS_PER_BLK)
   ) u_packer (
      .clk           (clk),
      .n_rst         (n_rst),
      .word          (bus.HWDATA),
      .accept        (accept),
      .clear         (clear),
      .blk_data      (blk_data),
      .blk_valid     (blk_valid),
      .framing_error (frm_err)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (bus.flush) begin
         // Sticky flags survive a flush; only fix_error or reset clears them.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         if (bus.fix_error) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (reject)                   ovf_q <= 1'b1;
            if (bus.rcv_deq && empty_w)   unf_q <= 1'b1;
         end
      end
   end

   // Storage is not reset; empty masks the stale head.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= blk_data;
   end

   assign bus.rcv_fifo_out  = empty_w ? '0 : mem[rd_ptr];
   assign bus.full          = full_w;
   assign bus.empty         = empty_w;
   assign bus.almost_full   = (count >= CNT_W'(AF_THRESH));
   assign bus.blk_count     = count;
   assign bus.framing_error = frm_err;
   assign bus.overflow      = ovf_q;
   assign bus.underflow     = unf_q;

endmodule

// File: tb/tb_rcv_block_fifo.sv
module tb_rcv_block_fifo;

   localparam int WORD_W = 32;
   localparam int WPB    = 4;
   localparam int DEPTH  = 3;
   localparam int AF     = 2;
   localparam int BLK_W  = WORD_W * WPB;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   rcv_block_fifo_if #(.WORD_W(WORD_W), .WORDS_PER_BLK(WPB), .DEPTH(DEPTH)) bus ();

   rcv_block_fifo #(.WORD_W(WORD_W), .WORDS_PER_BLK(WPB), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   // reference model
   logic [BLK_W-1:0] sb[$];
   logic [BLK_W-1:0] m_asm = '0;
   int               m_wc = 0;
   bit               m_ovf = 0, m_unf = 0;

   task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [BLK_W-1:0] head;
      head = (sb.size() != 0) ? sb[0] : '0;
      chk({tag, ".blk_count"},   BLK_W'(bus.blk_count),     BLK_W'(sb.size()));
      chk({tag, ".empty"},       BLK_W'(bus.empty),         BLK_W'(sb.size() == 0));
      chk({tag, ".full"},        BLK_W'(bus.full),          BLK_W'(sb.size() == DEPTH));
      chk({tag, ".almost_full"}, BLK_W'(bus.almost_full),   BLK_W'(sb.size() >= AF));
      chk({tag, ".framing"},     BLK_W'(bus.framing_error), BLK_W'(m_wc != 0));
      chk({tag, ".overflow"},    BLK_W'(bus.overflow),      BLK_W'(m_ovf));
      chk({tag, ".underflow"},   BLK_W'(bus.underflow),     BLK_W'(m_unf));
      chk({tag, ".head"},        bus.rcv_fifo_out,          head);
   endtask

   // One clock: drive at negedge, update model, release after the edge.
   task automatic cycle(input bit enq, input logic [WORD_W-1:0] w, input bit deq,
                        input bit fx = 1'b0, input bit fl = 1'b0);
      int n0;
      logic [BLK_W-1:0] exp;
      @(negedge clk);
      bus.HWDATA       = w;
      bus.rcv_enq_word = enq;
      bus.rcv_deq      = deq;
      bus.fix_error    = fx;
      bus.flush        = fl;
      n0 = sb.size();
      if (fl) begin
         sb.delete();
         m_wc  = 0;
         m_asm = '0;
      end else begin
         if (deq) begin
            if (n0 == 0) begin
               if (!fx) m_unf = 1;
            end else begin
               exp = sb.pop_front();
               chk("deq_head", bus.rcv_fifo_out, exp);
            end
         end
         if (fx) begin
            m_wc  = 0;
            m_asm = '0;
            m_ovf = 0;
            m_unf = 0;
         end else if (enq) begin
            if (n0 == DEPTH && !deq) m_ovf = 1;
            else begin
               m_asm[BLK_W-1-m_wc*WORD_W -: WORD_W] = w;
               m_wc++;
               if (m_wc == WPB) begin
                  sb.push_back(m_asm);
                  m_asm = '0;
                  m_wc  = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      bus.rcv_enq_word = 1'b0;
      bus.rcv_deq      = 1'b0;
      bus.fix_error    = 1'b0;
      bus.flush        = 1'b0;
   endtask

   task automatic model_reset();
      sb.delete();
      m_wc  = 0;
      m_asm = '0;
      m_ovf = 0;
      m_unf = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.HWDATA       = '0;
      bus.rcv_enq_word = 1'b0;
      bus.rcv_deq      = 1'b0;
      bus.fix_error    = 1'b0;
      bus.flush        = 1'b0;
      repeat (3) @(negedge clk);
      check_state("reset");
      n_rst = 1'b1;
      @(posedge clk); #1;
      check_state("post_reset");

      // 1: single block
      cycle(1, 32'hAA, 0);
      check_state("one_word");
      cycle(1, 32'hBB, 0);
      cycle(1, 32'hCC, 0);
      cycle(1, 32'hDD, 0);
      check_state("one_block");
      chk("one_block.value", bus.rcv_fifo_out, {32'hAA, 32'hBB, 32'hCC, 32'hDD});
      cycle(0, '0, 1);
      check_state("one_block_deq");

      // 2: fill, overflow, fix_error
      for (int i = 0; i < 12; i++) cycle(1, 32'h11 * (i + 1), 0);
      check_state("filled");
      chk("filled.head", bus.rcv_fifo_out, {32'h11, 32'h22, 32'h33, 32'h44});
      cycle(1, 32'hEE, 0);
      check_state("overflow");
      cycle(0, '0, 0, 1);
      check_state("fix_clears_ovf");

      // 3: completing word with coincident pop, pointer wrap
      cycle(1, 32'hD1, 1);
      check_state("d1_deq");
      cycle(1, 32'hD2, 0);
      cycle(1, 32'hD3, 0);
      cycle(1, 32'hD4, 1);
      check_state("push_pop");
      cycle(0, '0, 1);
      check_state("pop_b3");
      cycle(0, '0, 1);
      check_state("pop_b4");

      // 4: fix_error on partial block, underflow
      cycle(1, 32'h51, 0);
      cycle(1, 32'h52, 0);
      check_state("partial");
      cycle(0, '0, 0, 1);
      check_state("fix_partial");
      for (int i = 0; i < 4; i++) cycle(1, 32'h60 + i, 0);
      check_state("clean_block");
      cycle(0, '0, 1);
      cycle(0, '0, 1);
      check_state("underflow");

      // 5: flush with 2 blocks + 1 word, sticky underflow kept
      for (int i = 0; i < 9; i++) cycle(1, $urandom, 0);
      check_state("pre_flush");
      cycle(0, '0, 0, 0, 1);
      check_state("flushed");

      // 6: async reset mid-burst
      cycle(1, 32'h71, 0);
      cycle(1, 32'h72, 0);
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      model_reset();
      check_state("async_reset");
      @(posedge clk); #1;
      check_state("reset_edge");
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1, 32'h80 + i, 0);
      check_state("recover");
      cycle(0, '0, 1);
      check_state("recover_deq");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
